fifo_fwft: RTL and testbench

// - First-word-fall-through FIFO with valid/ready on both sides; successor to the basic queue.
// - Uses all 2**AWIDTH slots: no slot is sacrificed to tell full from empty.
// - Sustains 1 transfer/cycle and keeps a registered occupancy count.
// - Has programmable almost-full / almost-empty flags and a synchronous flush.
// - Sits between producer/consumer engines that need back-pressure without a combinational path.

---
 rtl/fifo_fwft_if.sv | 23 ++
 rtl/fifo_fwft.sv | 200 ++++++++++++++++++++
 tb/tb_fifo_fwft.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_fwft_if.sv
// Handshake bundle for fifo_fwft: write side (din/wr_valid/wr_ready) and
// read side (dout/rd_valid/rd_ready). The FIFO connects through the slave
// modport; the producer/consumer pair connects through the master modport.
interface fifo_fwft_if #(
  parameter int DWIDTH = 16
);
  logic [DWIDTH-1:0] din;
  logic              wr_valid;
  logic              wr_ready;
  logic [DWIDTH-1:0] dout;
  logic              rd_valid;
  logic              rd_ready;

  modport master (
    output din, wr_valid, rd_ready,
    input  wr_ready, dout, rd_valid
  );

  modport slave (
    input  din, wr_valid, rd_ready,
    output wr_ready, dout, rd_valid
  );
endinterface

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO, valid/ready on both sides, all 2**AWIDTH
// entries usable. Storage is a RAM with a synchronous read whose read
// register doubles as the prefetch stage, followed by an output register
// that drives dout. Occupancy is a registered count; fullness and the
// almost flags are derived from it, so wr_ready never depends on rd_ready.
//
// Optional feature: define FIFO_HWM_EN to build the high-water-mark
// register behind max_data_count_o; without it the port is tied to 0.
//
// Prefetch FSM (which stages hold valid data)
//   state            | meaning
//   ST_EMPTY         | nothing held, rd_valid low
//   ST_OUT           | one entry, in the output register
//   ST_OUT_PREF      | output and prefetch registers full, RAM empty
//   ST_OUT_PREF_MEM  | both registers full, remaining entries in RAM
// Stages always fill in order, so the state is a function of data_count.
module fifo_fwft #(
  parameter int DWIDTH     = 16,
  parameter int AWIDTH     = 7,
  parameter int AFULL_THR  = 120,
  parameter int AEMPTY_THR = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  fifo_fwft_if.slave        bus,
  output logic [AWIDTH:0]   data_count_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [AWIDTH:0]   max_data_count_o
);

  localparam int DEPTH = 2 ** AWIDTH;

  localparam logic [AWIDTH:0] FULL_CNT = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] AFULL_C  = (AWIDTH + 1)'(AFULL_THR);
  localparam logic [AWIDTH:0] AEMPTY_C = (AWIDTH + 1)'(AEMPTY_THR);

  localparam logic [1:0] ST_EMPTY        = 2'd0;
  localparam logic [1:0] ST_OUT          = 2'd1;
  localparam logic [1:0] ST_OUT_PREF     = 2'd2;
  localparam logic [1:0] ST_OUT_PREF_MEM = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DWIDTH-1:0] out_q, out_d;
  logic              rdy_en_q;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] pref_q;

  logic wr_ready_w;
  logic push, pop;
  logic out_v, pref_v, mem_v;
  logic out_take, pref_free;
  logic din_used;
  logic out_load, out_from_pref;
  logic pref_load, pref_from_mem;
  logic mem_we, rd_inc;

  // wr_ready comes only from registered state; rdy_en_q holds it low until
  // the first edge after reset is released.
  assign wr_ready_w   = rdy_en_q & (count_q != FULL_CNT);
  assign bus.wr_ready = wr_ready_w;
  assign bus.rd_valid = out_v;
  assign bus.dout     = out_q;

  assign data_count_o   = count_q;
  assign almost_full_o  = (count_q >= AFULL_C);
  assign almost_empty_o = (count_q <= AEMPTY_C);

  assign out_v  = (state_q != ST_EMPTY);
  assign pref_v = state_q[1];
  assign mem_v  = (state_q == ST_OUT_PREF_MEM);

  // Route the incoming word and refill the stages: the output register
  // takes from prefetch first, prefetch takes from RAM first, and the new
  // word lands in the earliest free stage that keeps the order intact.
  always_comb begin
    push          = bus.wr_valid & wr_ready_w & ~clear_i;
    pop           = out_v & bus.rd_ready & ~clear_i;
    out_take      = ~out_v | pop;
    pref_free     = ~pref_v | out_take;
    din_used      = 1'b0;
    out_load      = 1'b0;
    out_from_pref = 1'b0;
    pref_load     = 1'b0;
    pref_from_mem = 1'b0;
    mem_we        = 1'b0;
    rd_inc        = 1'b0;

    if (out_take) begin
      if (pref_v) begin
        out_load      = 1'b1;
        out_from_pref = 1'b1;
      end else if (push) begin
        out_load = 1'b1;
        din_used = 1'b1;
      end
    end

    if (pref_free) begin
      if (mem_v) begin
        pref_load     = 1'b1;
        pref_from_mem = 1'b1;
        rd_inc        = 1'b1;
      end else if (push && !din_used) begin
        pref_load = 1'b1;
        din_used  = 1'b1;
      end
    end

    if (push && !din_used) begin
      mem_we = 1'b1;
    end
  end

  // Next-state for count, pointers, output register and FSM.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    out_d    = out_q;

    if (push && !pop) begin
      count_d = count_q + (AWIDTH + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AWIDTH + 1)'(1);
    end
    if (mem_we) wr_ptr_d = wr_ptr_q + AWIDTH'(1);
    if (rd_inc) rd_ptr_d = rd_ptr_q + AWIDTH'(1);
    if (out_load) out_d = out_from_pref ? pref_q : bus.din;

    if (clear_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      out_d    = '0;
    end

    if (count_d == '0) begin
      state_d = ST_EMPTY;
    end else if (count_d == (AWIDTH + 1)'(1)) begin
      state_d = ST_OUT;
    end else if (count_d == (AWIDTH + 1)'(2)) begin
      state_d = ST_OUT_PREF;
    end else begin
      state_d = ST_OUT_PREF_MEM;
    end
  end

  // Control state and output register; async reset discards everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      out_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      out_q    <= out_d;
      rdy_en_q <= 1'b1;
    end
  end

  // RAM write port and synchronous read into the prefetch register.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= bus.din;
    end
    if (pref_load) begin
      pref_q <= pref_from_mem ? mem_q[rd_ptr_q] : bus.din;
    end
  end

`ifdef FIFO_HWM_EN
  logic [AWIDTH:0] max_q;

  // High-water mark tracks the peak count; survives clear, not reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
    end else if (count_q > max_q) begin
      max_q <= count_q;
    end
  end

  assign max_data_count_o = max_q;
`else
  assign max_data_count_o = '0;
`endif

endmodule

// File: tb/tb_fifo_fwft.sv
// Directed bench for fifo_fwft. Stimulus pushes expected words into a
// scoreboard queue; a separate monitor pops and compares on every read
// handshake. Main flow also checks count, flags and handshake state.
module tb_fifo_fwft;

  localparam int DW = 16;
  localparam int AW = 7;
`ifdef FIFO_HWM_EN
  localparam int EXP_HWM = 77;
`else
  localparam int EXP_HWM = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic [AW:0]   data_count;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   max_data_count;

  fifo_fwft_if #(.DWIDTH(DW)) bus ();

  fifo_fwft #(
    .DWIDTH(DW), .AWIDTH(AW), .AFULL_THR(120), .AEMPTY_THR(4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear_i          (clear),
    .bus              (bus),
    .data_count_o     (data_count),
    .almost_full_o    (almost_full),
    .almost_empty_o   (almost_empty),
    .max_data_count_o (max_data_count)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    bus.din      = d;
    bus.wr_valid = 1'b1;
    exp_q.push_back(d);
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_count(input int target, input int budget);
    int n = 0;
    while (data_count != (AW + 1)'(target) && n < budget) begin
      tick();
      n++;
    end
    chk("wait_count", 32'(data_count), 32'(target));
  endtask

  // Scoreboard monitor: every read handshake must match the queue head.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && !clear && bus.rd_valid && bus.rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop dout=%0h expected none t=%0t", bus.dout, $time);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", 32'(bus.dout), 32'(e));
        end
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    clear        = 1'b0;
    bus.din      = '0;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;

    // reset state
    #2;
    chk("rst_count", 32'(data_count), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_aempty", 32'(almost_empty), 1);
    #20;
    rst_n = 1'b1;
    #1;
    chk("wr_ready_before_edge", 32'(bus.wr_ready), 0);
    tick();
    chk("wr_ready_after_edge", 32'(bus.wr_ready), 1);

    // single word, held until rd_ready
    push_word(16'hA5A5);
    chk("single_rd_valid", 32'(bus.rd_valid), 1);
    chk("single_dout", 32'(bus.dout), 32'h0000A5A5);
    chk("single_count", 32'(data_count), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_rd_valid", 32'(bus.rd_valid), 1);
      chk("hold_dout", 32'(bus.dout), 32'h0000A5A5);
    end
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    chk("single_drained", 32'(data_count), 0);
    chk("single_rd_valid_low", 32'(bus.rd_valid), 0);

    // fill 0..127, almost_full at 120, then full
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 128; i++) begin
      bus.din = DW'(i);
      exp_q.push_back(DW'(i));
      tick();
      chk("fill_count", 32'(data_count), 32'(i + 1));
      chk("fill_afull", 32'(almost_full), 32'((i + 1) >= 120));
    end
    chk("full_wr_ready", 32'(bus.wr_ready), 0);
    bus.din = 16'hFFFF;
    tick();
    bus.wr_valid = 1'b0;
    chk("full_no_push", 32'(data_count), 128);
    bus.rd_ready = 1'b1;
    wait_count(0, 300);
    bus.rd_ready = 1'b0;
    chk("fill_sb_empty", 32'(exp_q.size()), 0);

    // streaming at count 5
    for (int i = 0; i < 5; i++) push_word(DW'(16'h1000 + i));
    chk("stream_pre_count", 32'(data_count), 5);
    bus.wr_valid = 1'b1;
    bus.rd_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      bus.din = DW'(16'h2000 + k);
      exp_q.push_back(DW'(16'h2000 + k));
      tick();
      chk("stream_count", 32'(data_count), 5);
      chk("stream_rd_valid", 32'(bus.rd_valid), 1);
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;

    // almost_empty boundary
    chk("flag_ae_at5", 32'(almost_empty), 0);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    chk("flag_count4", 32'(data_count), 4);
    chk("flag_ae_at4", 32'(almost_empty), 1);
    push_word(16'h3000);
    chk("flag_count5", 32'(data_count), 5);
    chk("flag_ae_back", 32'(almost_empty), 0);

    // clear at count 60 with simultaneous push and pop request
    for (int i = 0; i < 55; i++) push_word(DW'(16'h4000 + i));
    chk("clear_pre_count", 32'(data_count), 60);
    clear        = 1'b1;
    bus.din      = 16'hDEAD;
    bus.wr_valid = 1'b1;
    bus.rd_ready = 1'b1;
    tick();
    clear        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    exp_q.delete();
    chk("clear_count", 32'(data_count), 0);
    chk("clear_rd_valid", 32'(bus.rd_valid), 0);
    chk("clear_wr_ready", 32'(bus.wr_ready), 1);
    chk("clear_dout", 32'(bus.dout), 0);
    chk("clear_aempty", 32'(almost_empty), 1);
    push_word(16'h1234);
    chk("post_clear_dout", 32'(bus.dout), 32'h00001234);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    chk("post_clear_count", 32'(data_count), 0);

    // async reset mid-stream at count 30
    for (int i = 0; i < 30; i++) push_word(DW'(16'h5000 + i));
    chk("areset_pre_count", 32'(data_count), 30);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("areset_rd_valid", 32'(bus.rd_valid), 0);
    chk("areset_count", 32'(data_count), 0);
    chk("areset_wr_ready", 32'(bus.wr_ready), 0);
    chk("areset_dout", 32'(bus.dout), 0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("areset_wr_ready_up", 32'(bus.wr_ready), 1);
    chk("areset_count_after", 32'(data_count), 0);

    // high-water mark: peak 77 then drain
    for (int i = 0; i < 77; i++) push_word(DW'(16'h6000 + i));
    chk("hwm_peak_count", 32'(data_count), 77);
    tick();
    bus.rd_ready = 1'b1;
    wait_count(0, 200);
    bus.rd_ready = 1'b0;
    tick();
    chk("hwm_value", 32'(max_data_count), 32'(EXP_HWM));

    chk("final_sb_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout reached t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
